// File: rtl/zap_gpio_mmio.sv
// ZAP GPIO MMIO block: 8-register window providing output pins with
// set/clear/toggle aliases and a prescaled blink engine.
module zap_gpio_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_2000,
  parameter int unsigned NUM_PINS   = 8,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic [31:0]         i_address,
  input  logic                i_wr_en,
  input  logic                i_rd_en,
  input  logic [3:0]          i_ben,
  input  logic [31:0]         i_wr_data,
  output logic [31:0]         o_rd_data,
  output logic                o_rd_valid,
  output logic [NUM_PINS-1:0] o_gpio
);

  typedef enum logic [2:0] {
    REG_OUT      = 3'd0,
    REG_SET      = 3'd1,
    REG_CLR      = 3'd2,
    REG_TGL      = 3'd3,
    REG_BLINK_EN = 3'd4,
    REG_PERIOD   = 3'd5,
    REG_COUNT    = 3'd6,
    REG_RSVD     = 3'd7
  } reg_e;

  logic [NUM_PINS-1:0]   out_q, out_d;
  logic [NUM_PINS-1:0]   blink_en_q, blink_en_d;
  logic [PRESCALE_W-1:0] period_q, period_d;
  logic [PRESCALE_W-1:0] count_q, count_d;
  logic [31:0]           rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  reg_e                  offset;
  logic                  hit;
  logic                  wr_hit;
  logic                  rd_hit;
  logic                  tick;
  logic [31:0]           bmask;
  logic [NUM_PINS-1:0]   bm_pins;
  logic [PRESCALE_W-1:0] bm_per;
  logic [NUM_PINS-1:0]   store_mod;
  logic [NUM_PINS-1:0]   store_val;
  logic [NUM_PINS-1:0]   out_blink;
  logic [31:0]           rd_word;

  // Address byte offset and the upper store-data bits beyond the register widths carry no meaning.
  logic unused_inputs;
  assign unused_inputs = ^{i_address[1:0], i_wr_data};

  assign offset = reg_e'(i_address[4:2]);
  assign hit    = (i_address[31:5] == BASE_ADDR[31:5]);
  assign wr_hit = i_wr_en & hit;
  assign rd_hit = i_rd_en & hit;

  // Expand byte enables into a per-bit write mask.
  always_comb begin
    bmask = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      bmask[8*k +: 8] = {8{i_ben[k]}};
    end
    bm_pins = bmask[NUM_PINS-1:0];
    bm_per  = bmask[PRESCALE_W-1:0];
  end

  // Blink prescaler: wraps after PERIOD+1 cycles, idle at PERIOD=0, restarted by PERIOD stores.
  always_comb begin
    tick    = (period_q != '0) && (count_q == period_q);
    count_d = count_q;
    if (wr_hit && (offset == REG_PERIOD) && (i_ben != 4'b0000)) begin
      count_d = '0;
    end else if ((period_q == '0) || tick) begin
      count_d = '0;
    end else begin
      count_d = count_q + PRESCALE_W'(1);
    end
  end

  // OUT update: bits touched by a CPU store take the store result, remaining bits take the tick.
  always_comb begin
    store_mod = '0;
    store_val = '0;
    if (wr_hit) begin
      case (offset)
        REG_OUT: begin
          store_mod = bm_pins;
          store_val = i_wr_data[NUM_PINS-1:0];
        end
        REG_SET: begin
          store_mod = bm_pins & i_wr_data[NUM_PINS-1:0];
          store_val = '1;
        end
        REG_CLR: begin
          store_mod = bm_pins & i_wr_data[NUM_PINS-1:0];
          store_val = '0;
        end
        REG_TGL: begin
          store_mod = bm_pins & i_wr_data[NUM_PINS-1:0];
          store_val = ~out_q;
        end
        default: begin
          store_mod = '0;
          store_val = '0;
        end
      endcase
    end
    out_blink = tick ? (out_q ^ blink_en_q) : out_q;
    out_d     = (store_mod & store_val) | (~store_mod & out_blink);
  end

  // BLINK_EN and PERIOD byte-masked read/write registers.
  always_comb begin
    blink_en_d = blink_en_q;
    period_d   = period_q;
    if (wr_hit && (offset == REG_BLINK_EN)) begin
      blink_en_d = (blink_en_q & ~bm_pins) | (i_wr_data[NUM_PINS-1:0] & bm_pins);
    end
    if (wr_hit && (offset == REG_PERIOD)) begin
      period_d = (period_q & ~bm_per) | (i_wr_data[PRESCALE_W-1:0] & bm_per);
    end
  end

  // Read mux on pre-edge state so a same-cycle store does not leak into the load.
  always_comb begin
    rd_word = '0;
    case (offset)
      REG_OUT:      rd_word[NUM_PINS-1:0]   = out_q;
      REG_BLINK_EN: rd_word[NUM_PINS-1:0]   = blink_en_q;
      REG_PERIOD:   rd_word[PRESCALE_W-1:0] = period_q;
      REG_COUNT:    rd_word[PRESCALE_W-1:0] = count_q;
      default:      rd_word = '0;
    endcase
    rd_valid_d = rd_hit;
    rd_data_d  = rd_hit ? rd_word : rd_data_q;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      out_q      <= '0;
      blink_en_q <= '0;
      period_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      blink_en_q <= blink_en_d;
      period_q   <= period_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign o_gpio     = out_q;
  assign o_rd_data  = rd_data_q;
  assign o_rd_valid = rd_valid_q;

endmodule

// File: tb/tb_zap_gpio_mmio.sv
// Directed testbench for zap_gpio_mmio (default 8 pins, 16-bit prescaler).
module tb_zap_gpio_mmio;

  localparam logic [31:0] A_OUT = 32'h0000_2000;
  localparam logic [31:0] A_SET = 32'h0000_2004;
  localparam logic [31:0] A_CLR = 32'h0000_2008;
  localparam logic [31:0] A_TGL = 32'h0000_200C;
  localparam logic [31:0] A_BEN = 32'h0000_2010;
  localparam logic [31:0] A_PER = 32'h0000_2014;
  localparam logic [31:0] A_CNT = 32'h0000_2018;
  localparam logic [31:0] A_RSV = 32'h0000_201C;

  logic        clk;
  logic        reset_n;
  logic [31:0] address;
  logic        wr_en;
  logic        rd_en;
  logic [3:0]  ben;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [7:0]  gpio;

  int errors = 0;
  int checks = 0;

  zap_gpio_mmio #(
    .BASE_ADDR (32'h0000_2000),
    .NUM_PINS  (8),
    .PRESCALE_W(16)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_address (address),
    .i_wr_en   (wr_en),
    .i_rd_en   (rd_en),
    .i_ben     (ben),
    .i_wr_data (wr_data),
    .o_rd_data (rd_data),
    .o_rd_valid(rd_valid),
    .o_gpio    (gpio)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Tasks are entered at a falling edge and return at the next falling edge (one rising edge used).
  task automatic bus_write(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    address = a; ben = b; wr_data = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; ben = 4'b0000;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
    address = a; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    d = rd_data;
    v = rd_valid;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b1; address = '0; wr_en = 1'b0; rd_en = 1'b0; ben = '0; wr_data = '0;
    #1 reset_n = 1'b0;
    #1;
    checks++; if (gpio !== 8'h00) begin errors++; $display("FAIL reset_gpio: got=%h exp=%h", gpio, 8'h00); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got=%b exp=0", rd_valid); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rdata: got=%h exp=%h", rd_data, 32'h0); end
    idle(2);
    reset_n = 1'b1;
  endtask

  task automatic test_out_rw();
    logic [31:0] d; logic v;
    bus_write(A_OUT, 4'b0001, 32'h0000_00A5);
    checks++; if (gpio !== 8'hA5) begin errors++; $display("FAIL out_write: gpio=%h exp=%h", gpio, 8'hA5); end
    bus_read(A_OUT, d, v);
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL out_read_valid: got=%b exp=1", v); end
    checks++; if (d !== 32'h0000_00A5) begin errors++; $display("FAIL out_read_data: got=%h exp=%h", d, 32'h0000_00A5); end
    idle(1);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse: got=%b exp=0", rd_valid); end
    checks++; if (rd_data !== 32'h0000_00A5) begin errors++; $display("FAIL rdata_hold: got=%h exp=%h", rd_data, 32'h0000_00A5); end
  endtask

  task automatic test_set_clr_tgl();
    logic [31:0] d; logic v;
    bus_write(A_OUT, 4'b1111, 32'h0000_00F0);
    bus_write(A_SET, 4'b1111, 32'h0000_000F);
    checks++; if (gpio !== 8'hFF) begin errors++; $display("FAIL set: gpio=%h exp=%h", gpio, 8'hFF); end
    bus_write(A_CLR, 4'b1111, 32'h0000_0081);
    checks++; if (gpio !== 8'h7E) begin errors++; $display("FAIL clr: gpio=%h exp=%h", gpio, 8'h7E); end
    bus_write(A_TGL, 4'b1111, 32'h0000_0003);
    checks++; if (gpio !== 8'h7D) begin errors++; $display("FAIL tgl: gpio=%h exp=%h", gpio, 8'h7D); end
    bus_read(A_SET, d, v);
    checks++; if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL set_raz: data=%h valid=%b exp=00000000/1", d, v); end
    // Disabled byte lane: SET with ben=0 must not touch OUT.
    bus_write(A_SET, 4'b0000, 32'h0000_00FF);
    checks++; if (gpio !== 8'h7D) begin errors++; $display("FAIL set_ben0: gpio=%h exp=%h", gpio, 8'h7D); end
  endtask

  task automatic test_byte_enables();
    logic [31:0] d; logic v;
    bus_write(A_OUT, 4'b0010, 32'hFFFF_FFFF);
    checks++; if (gpio !== 8'h7D) begin errors++; $display("FAIL ben_upper: gpio=%h exp=%h", gpio, 8'h7D); end
    bus_read(A_OUT, d, v);
    checks++; if (d !== 32'h0000_007D) begin errors++; $display("FAIL out_upper_raz: got=%h exp=%h", d, 32'h0000_007D); end
    // Low address bits are ignored.
    bus_read(32'h0000_2003, d, v);
    checks++; if (v !== 1'b1 || d !== 32'h0000_007D) begin errors++; $display("FAIL addr_lowbits: data=%h valid=%b exp=0000007d/1", d, v); end
  endtask

  task automatic test_miss_and_reserved();
    logic [31:0] d; logic v;
    bus_read(32'h0000_3000, d, v);
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL miss_valid: got=%b exp=0", v); end
    checks++; if (d !== 32'h0000_007D) begin errors++; $display("FAIL miss_hold: got=%h exp=%h", d, 32'h0000_007D); end
    bus_write(32'h0000_3000, 4'b1111, 32'h0000_0000);
    checks++; if (gpio !== 8'h7D) begin errors++; $display("FAIL miss_write: gpio=%h exp=%h", gpio, 8'h7D); end
    bus_write(A_RSV, 4'b1111, 32'hFFFF_FFFF);
    bus_write(A_CNT, 4'b1111, 32'h0000_1234);
    bus_read(A_RSV, d, v);
    checks++; if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL rsvd_raz: data=%h valid=%b exp=00000000/1", d, v); end
    bus_read(A_CNT, d, v);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL count_ro: got=%h exp=%h", d, 32'h0); end
    checks++; if (gpio !== 8'h7D) begin errors++; $display("FAIL rsvd_no_effect: gpio=%h exp=%h", gpio, 8'h7D); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic v;
    address = A_OUT; ben = 4'b1111; wr_data = 32'h0000_0011; wr_en = 1'b1; rd_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; ben = 4'b0000;
    checks++; if (rd_data !== 32'h0000_007D) begin errors++; $display("FAIL rw_collision_data: got=%h exp=%h", rd_data, 32'h0000_007D); end
    checks++; if (gpio !== 8'h11) begin errors++; $display("FAIL rw_collision_gpio: gpio=%h exp=%h", gpio, 8'h11); end
    bus_read(A_OUT, d, v);
    checks++; if (d !== 32'h0000_0011) begin errors++; $display("FAIL b2b_read: got=%h exp=%h", d, 32'h0000_0011); end
  endtask

  task automatic test_blink();
    logic [31:0] d; logic v;
    logic [7:0] exp_g;
    bus_write(A_OUT, 4'b1111, 32'h0);
    bus_write(A_BEN, 4'b0001, 32'h0000_0001);
    bus_write(A_PER, 4'b0011, 32'h0000_0003);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_g = ((k / 4) % 2 == 1) ? 8'h01 : 8'h00;
      checks++; if (gpio !== exp_g) begin errors++; $display("FAIL blink_cycle%0d: gpio=%h exp=%h", k, gpio, exp_g); end
    end
    idle(1);
    bus_read(A_CNT, d, v);
    checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL count_value: got=%h exp=%h", d, 32'h0000_0001); end
    bus_write(A_PER, 4'b0001, 32'h0);
    idle(6);
    checks++; if (gpio !== 8'h00) begin errors++; $display("FAIL period0_freeze: gpio=%h exp=%h", gpio, 8'h00); end
    bus_read(A_CNT, d, v);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL period0_count: got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_tick_priority();
    bus_write(A_BEN, 4'b0001, 32'h0000_0003);
    bus_write(A_OUT, 4'b0001, 32'h0000_0003);
    bus_write(A_PER, 4'b0001, 32'h0000_0003);
    idle(3);
    checks++; if (gpio !== 8'h03) begin errors++; $display("FAIL pre_tick: gpio=%h exp=%h", gpio, 8'h03); end
    bus_write(A_CLR, 4'b0001, 32'h0000_0001);
    checks++; if (gpio !== 8'h00) begin errors++; $display("FAIL tick_vs_clr: gpio=%h exp=%h", gpio, 8'h00); end
    idle(3);
    checks++; if (gpio !== 8'h00) begin errors++; $display("FAIL between_ticks: gpio=%h exp=%h", gpio, 8'h00); end
    idle(1);
    checks++; if (gpio !== 8'h03) begin errors++; $display("FAIL second_tick: gpio=%h exp=%h", gpio, 8'h03); end
    bus_write(A_PER, 4'b0001, 32'h0);
    bus_write(A_BEN, 4'b0001, 32'h0);
  endtask

  task automatic test_period_width();
    logic [31:0] d; logic v;
    bus_write(A_PER, 4'b1111, 32'hFFFF_FFFF);
    bus_read(A_PER, d, v);
    checks++; if (d !== 32'h0000_FFFF) begin errors++; $display("FAIL period_mask: got=%h exp=%h", d, 32'h0000_FFFF); end
    bus_read(A_CNT, d, v);
    checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL count_incr: got=%h exp=%h", d, 32'h0000_0001); end
    bus_write(A_PER, 4'b0001, 32'h0);
  endtask

  task automatic test_reset_midblink();
    logic [31:0] d; logic v;
    bus_write(A_BEN, 4'b0001, 32'h0000_0001);
    bus_write(A_OUT, 4'b0001, 32'h0000_00FF);
    bus_write(A_PER, 4'b0001, 32'h0000_0002);
    idle(1);
    address = A_OUT; rd_en = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (gpio !== 8'h00) begin errors++; $display("FAIL async_reset_gpio: gpio=%h exp=%h", gpio, 8'h00); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got=%b exp=0", rd_valid); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL async_reset_rdata: got=%h exp=%h", rd_data, 32'h0); end
    @(negedge clk);
    rd_en = 1'b0;
    idle(1);
    reset_n = 1'b1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL pending_load_dropped: got=%b exp=0", rd_valid); end
    bus_write(A_OUT, 4'b0001, 32'h0000_005A);
    checks++; if (gpio !== 8'h5A) begin errors++; $display("FAIL first_edge_store: gpio=%h exp=%h", gpio, 8'h5A); end
    idle(8);
    checks++; if (gpio !== 8'h5A) begin errors++; $display("FAIL no_tick_after_reset: gpio=%h exp=%h", gpio, 8'h5A); end
    bus_read(A_PER, d, v);
    checks++; if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL period_after_reset: data=%h valid=%b exp=00000000/1", d, v); end
    bus_read(A_BEN, d, v);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL blink_en_after_reset: got=%h exp=%h", d, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_out_rw();
    test_set_clr_tgl();
    test_byte_enables();
    test_miss_and_reserved();
    test_back_to_back();
    test_blink();
    test_tick_priority();
    test_period_width();
    test_reset_midblink();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/zap_gpio_mmio.md
ZAP_GPIO_MMIO -- requirements
Module: zap_gpio_mmio

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_2000, giving the byte address of the 32-byte register window, 32-byte aligned.
REQ-002 The block SHALL have parameter NUM_PINS, default 8, giving the number of output pins, legal range 1..32.
REQ-003 The block SHALL have parameter PRESCALE_W, default 16, giving the width of the blink period and counter, legal range 1..32.
REQ-004 The block SHALL have port i_clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port i_reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port i_address, input, 32 bits: byte address from the ZAP data port.
REQ-007 The block SHALL have port i_wr_en, input, 1 bit: store strobe.
REQ-008 The block SHALL have port i_rd_en, input, 1 bit: load strobe.
REQ-009 The block SHALL have port i_ben, input, 4 bits: byte enables for stores.
REQ-010 The block SHALL have port i_wr_data, input, 32 bits: store data.
REQ-011 The block SHALL have port o_rd_data, output, 32 bits: registered load data.
REQ-012 The block SHALL have port o_rd_valid, output, 1 bit: one-cycle pulse qualifying o_rd_data.
REQ-013 The block SHALL have port o_gpio, output, NUM_PINS bits: pin outputs, driven directly from the OUT register.

Function
REQ-014 Hit SHALL be i_address[31:5] == BASE_ADDR[31:5]; offset = i_address[4:2]; i_address[1:0] is ignored.
REQ-015 Register map: 0 OUT (RW), 1 SET (W1S to OUT), 2 CLR (W1C to OUT), 3 TGL (W1T to OUT), 4 BLINK_EN (RW), 5 PERIOD (RW, PRESCALE_W bits), 6 COUNT (RO), 7 reserved (RAZ/WI).
REQ-016 Stores SHALL take effect on the rising edge where i_wr_en=1 and hit=1; i_ben[k] qualifies bits [8k+7:8k] only.
REQ-017 Bits at or above NUM_PINS (or PRESCALE_W for PERIOD/COUNT) SHALL be write-ignored and read as 0.
REQ-018 SET/CLR/TGL SHALL read as 0; stores to COUNT and reserved offsets SHALL have no effect.
REQ-019 Loads: i_rd_en=1 with hit=1 SHALL return the addressed register on o_rd_data with o_rd_valid=1 exactly one cycle later (latency 1).
REQ-020 o_rd_data SHALL hold its last value when o_rd_valid=0; a load without a hit SHALL produce no o_rd_valid pulse.
REQ-021 If i_wr_en and i_rd_en are both asserted in one cycle, the load SHALL return the pre-write value.
REQ-022 Blink counter: when PERIOD != 0, COUNT SHALL increment each cycle.
REQ-023 When COUNT == PERIOD, the next cycle SHALL set COUNT to 0 and assert a one-cycle tick; the tick period is therefore PERIOD+1 cycles.
REQ-024 When PERIOD == 0, COUNT SHALL hold at 0 and no tick SHALL occur.
REQ-025 Any store to PERIOD (any byte enable set) SHALL clear COUNT to 0 on the same edge.
REQ-026 On a tick, OUT bits with BLINK_EN=1 SHALL invert.
REQ-027 Same-cycle priority per bit: a bit modified by a CPU store to OUT/SET/CLR/TGL SHALL take the store result, computed from pre-edge OUT, and SHALL ignore the tick.
REQ-028 Bits not modified by the CPU store SHALL apply the tick.
REQ-029 A SET/CLR/TGL store SHALL modify only those enabled bits whose data bit is 1.

Reset
REQ-030 While i_reset_n=0, OUT, BLINK_EN, PERIOD, COUNT, o_rd_data and o_rd_valid SHALL be 0 immediately, independent of i_clk.
REQ-031 A pending load at reset assertion SHALL be discarded.
REQ-032 After reset release, the first rising edge SHALL accept a store or load normally.
REQ-033 Reset asserted mid-blink SHALL leave o_gpio=0 with no tick occurring until PERIOD is rewritten.

Verification
REQ-034 Store 0xA5 to OUT (ben=4'b0001), then load OUT -> o_gpio=8'hA5; o_rd_data=32'h0000_00A5 with o_rd_valid one cycle after the load.
REQ-035 OUT=0xF0; SET 0x0F; CLR 0x81; TGL 0x03 -> o_gpio sequence 0xFF, 0x7E, 0x7D.
REQ-036 Store 32'hFFFF_FFFF to OUT with ben=4'b0010 (NUM_PINS=8) -> OUT unchanged; load returns upper bits 0.
REQ-037 BLINK_EN=0x01, PERIOD=3 -> bit0 toggles every 4 cycles; writing PERIOD=0 freezes COUNT at 0 and stops toggling.
REQ-038 Tick coincides with CLR 0x01 while BLINK_EN=0x03, OUT=0x03 -> OUT=0x00 (bit0 from store, bit1 from tick).
REQ-039 Drop i_reset_n asynchronously between clock edges while blinking -> o_gpio=0 and o_rd_valid=0 before the next edge; no ticks afterwards.
